// File: rtl/nbody_pair_scheduler.sv
// Pair sequencer for the pipelined N-body acceleration calculator: issues every
// ordered (i, j) pair, closes the per-body accumulation loop and streams results.
module nbody_pair_scheduler #(
   parameter int N_MAX   = 16,
   parameter int IDX_W   = 4,
   parameter int ACC_LAT = 24,
   parameter int ADD_TAP = 22
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [IDX_W:0]   i_n_bodies,
   output logic             o_busy,
   output logic             o_done,
   output logic [IDX_W-1:0] o_rd_i_addr,
   output logic [IDX_W-1:0] o_rd_j_addr,
   input  logic [31:0]      i_rd_i_x,
   input  logic [31:0]      i_rd_i_y,
   input  logic [31:0]      i_rd_j_x,
   input  logic [31:0]      i_rd_j_y,
   input  logic [31:0]      i_rd_j_m,
   output logic [31:0]      o_b1_x,
   output logic [31:0]      o_b1_y,
   output logic [31:0]      o_b2_x,
   output logic [31:0]      o_b2_y,
   output logic [31:0]      o_m_b2,
   output logic             o_pair_valid,
   output logic [31:0]      o_a_b1_x,
   output logic [31:0]      o_a_b1_y,
   input  logic [31:0]      i_acc_x,
   input  logic [31:0]      i_acc_y,
   output logic             o_acc_valid,
   output logic [IDX_W-1:0] o_acc_idx,
   output logic [31:0]      o_acc_x,
   output logic [31:0]      o_acc_y
);

   localparam int MIN_P = ACC_LAT - ADD_TAP + 1;
   localparam int S_W   = $clog2(N_MAX + MIN_P + 1);
   localparam int D_W   = $clog2(ACC_LAT + 2);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   state_t           state_q, state_d;
   logic             done_d;
   logic [S_W-1:0]   n_q, p_q, s_cnt, j_cnt;
   logic [D_W-1:0]   d_cnt;
   logic [S_W-1:0]   n_in, p_in;
   logic             last_slot, last_round, out_last;
   logic             issue, s_in_range, slot_real;
   logic             s1_slot, s1_real;
   logic [IDX_W-1:0] s1_idx, iss_idx;
   tag_t             tag_pipe [ACC_LAT];
   tag_t             rd_tag, wb_tag;
   logic [31:0]      part_x [N_MAX];
   logic [31:0]      part_y [N_MAX];

   assign n_in       = S_W'(i_n_bodies);
   assign p_in       = (n_in > S_W'(MIN_P)) ? n_in : S_W'(MIN_P);
   assign last_slot  = (s_cnt == p_q - S_W'(1));
   assign last_round = (j_cnt == n_q - S_W'(1));
   assign out_last   = (s_cnt == n_q - S_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         o_done  <= 1'b0;
      end else begin
         state_q <= state_d;
         o_done  <= done_d;
      end
   end

   // NOTE: defaults come first so no path leaves a variable unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE:   if (i_start) begin
                      if (i_n_bodies == '0) done_d = 1'b1;
                      else                  state_d = S_CLEAR;
                   end
         S_CLEAR:  state_d = (n_q == S_W'(1)) ? S_OUTPUT : S_ISSUE;
         S_ISSUE:  if (last_slot && last_round) state_d = S_DRAIN;
         // Two extra cycles cover the memory read and the issue register.
         S_DRAIN:  if (d_cnt == D_W'(ACC_LAT + 1)) state_d = S_OUTPUT;
         S_OUTPUT: if (out_last) begin
                      state_d = S_IDLE;
                      done_d  = 1'b1;
                   end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         n_q   <= '0;
         p_q   <= '0;
         s_cnt <= '0;
         j_cnt <= '0;
         d_cnt <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               s_cnt <= '0;
               j_cnt <= '0;
               d_cnt <= '0;
               if (i_start) begin
                  n_q <= n_in;
                  p_q <= p_in;
               end
            end
            S_ISSUE:
               if (last_slot) begin
                  s_cnt <= '0;
                  j_cnt <= j_cnt + S_W'(1);
               end else begin
                  s_cnt <= s_cnt + S_W'(1);
               end
            S_DRAIN:  d_cnt <= d_cnt + D_W'(1);
            S_OUTPUT: s_cnt <= s_cnt + S_W'(1);
            default: begin
               s_cnt <= '0;
               j_cnt <= '0;
               d_cnt <= '0;
            end
         endcase
      end
   end

   assign issue       = (state_q == S_ISSUE);
   assign s_in_range  = (s_cnt < n_q);
   assign slot_real   = issue && s_in_range && (s_cnt != j_cnt);
   assign o_rd_i_addr = (issue && s_in_range) ? s_cnt[IDX_W-1:0] : '0;
   assign o_rd_j_addr = issue ? j_cnt[IDX_W-1:0] : '0;

   // Address cycle -> memory read cycle -> issue cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_slot      <= 1'b0;
         s1_real      <= 1'b0;
         s1_idx       <= '0;
         o_b1_x       <= '0;
         o_b1_y       <= '0;
         o_b2_x       <= '0;
         o_b2_y       <= '0;
         o_m_b2       <= '0;
         o_pair_valid <= 1'b0;
         iss_idx      <= '0;
      end else begin
         s1_slot      <= issue;
         s1_real      <= slot_real;
         s1_idx       <= o_rd_i_addr;
         o_b1_x       <= s1_slot ? i_rd_i_x : '0;
         o_b1_y       <= s1_slot ? i_rd_i_y : '0;
         o_b2_x       <= s1_slot ? i_rd_j_x : '0;
         o_b2_y       <= s1_slot ? i_rd_j_y : '0;
         o_m_b2       <= s1_slot ? i_rd_j_m : '0;
         o_pair_valid <= s1_real;
         iss_idx      <= s1_idx;
      end
   end

   assign rd_tag = tag_pipe[ADD_TAP-1];
   assign wb_tag = tag_pipe[ACC_LAT-1];

   // NOTE: the partial array is cleared by reset, so it must remain flops rather than a RAM macro.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < ACC_LAT; k++) tag_pipe[k] <= '0;
         for (int k = 0; k < N_MAX; k++) begin
            part_x[k] <= '0;
            part_y[k] <= '0;
         end
      end else if (state_q == S_CLEAR) begin
         for (int k = 0; k < ACC_LAT; k++) tag_pipe[k] <= '0;
         for (int k = 0; k < N_MAX; k++) begin
            part_x[k] <= '0;
            part_y[k] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{valid: o_pair_valid, idx: iss_idx};
         for (int k = 1; k < ACC_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
         if (wb_tag.valid) begin
            part_x[wb_tag.idx] <= i_acc_x;
            part_y[wb_tag.idx] <= i_acc_y;
         end
      end
   end

   assign o_a_b1_x    = rd_tag.valid ? part_x[rd_tag.idx] : '0;
   assign o_a_b1_y    = rd_tag.valid ? part_y[rd_tag.idx] : '0;
   assign o_acc_valid = (state_q == S_OUTPUT);
   assign o_acc_idx   = o_acc_valid ? s_cnt[IDX_W-1:0] : '0;
   assign o_acc_x     = o_acc_valid ? part_x[s_cnt[IDX_W-1:0]] : '0;
   assign o_acc_y     = o_acc_valid ? part_y[s_cnt[IDX_W-1:0]] : '0;
   assign o_busy      = (state_q != S_IDLE) || o_done;

endmodule

// File: doc/nbody_pair_scheduler.md
# nbody_pair_scheduler

Upstream sequencer for the pipelined acceleration calculator. For a frame of `n` bodies, it reads positions and masses from body memory and issues every ordered pair (i, j), i≠j, into the calculator, one pair per slot. It closes the accumulation loop by presenting each body's running partial acceleration on the calculator's previous-acceleration inputs and capturing the updated sum. After the last pair it streams the final per-body accelerations to the integrator.

## Interface
Parameters:
- `N_MAX`, 16: maximum bodies per frame.
- `IDX_W`, 4: body index width, equal to clog2(N_MAX).
- `ACC_LAT`, 24: cycles from pair issue to the calculator's result on `i_acc_x/y`.
- `ADD_TAP`, 22: cycles from pair issue to the calculator sampling its previous-acceleration inputs. Must satisfy ADD_TAP < ACC_LAT.

Ports (clock and reset first):
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, asynchronous and active-high.
- `i_start` in 1: one-cycle frame start pulse.
- `i_n_bodies` in IDX_W+1: body count, latched on start.
- `o_busy` out 1: high while a frame is in progress.
- `o_done` out 1: one-cycle pulse at end of frame.
- `o_rd_i_addr`, `o_rd_j_addr` out IDX_W: body-memory read addresses. Memory has a 1-cycle synchronous read.
- `i_rd_i_x`, `i_rd_i_y`, `i_rd_j_x`, `i_rd_j_y`, `i_rd_j_m` in 32: memory read data.
- `o_b1_x`, `o_b1_y`, `o_b2_x`, `o_b2_y`, `o_m_b2` out 32: registered pair data to the calculator.
- `o_pair_valid` out 1: issue-slot qualifier, for debug and bench use.
- `o_a_b1_x`, `o_a_b1_y` out 32: partial acceleration to the calculator.
- `i_acc_x`, `i_acc_y` in 32: calculator result.
- `o_acc_valid` out 1, `o_acc_idx` out IDX_W, `o_acc_x`, `o_acc_y` out 32: result stream.

## Operation
- **FSM states:**
  - IDLE: waits for `i_start`.
  - CLEAR (1 cycle): zeroes the `partial[0..N_MAX-1]` array and the tag pipe.
  - ISSUE: issues pairs.
  - DRAIN: waits ACC_LAT cycles.
  - OUTPUT: streams n results.
  - IDLE: `o_done` pulses as the FSM returns here.
- **Start handling:**
  - `i_start` is honoured only in IDLE.
  - n=0: goes IDLE→IDLE with `o_done` pulsed the next cycle and no results.
  - n=1: skips ISSUE and DRAIN, then outputs one zero result.
- **Round structure:**
  - Round period P = max(n, ACC_LAT−ADD_TAP+1).
  - Outer counter j runs 0..n−1. Inner slot counter s runs 0..P−1.
  - Addresses for the slot: `o_rd_i_addr`=s (0 when s≥n), `o_rd_j_addr`=j.
  - The slot is real when s<n and s≠j. Otherwise it is a bubble.
- **Issue:** addresses are driven at cycle a. Data is registered to the `o_b*`/`o_m_b2` outputs at cycle a+2, which is the issue cycle t.
  - `o_pair_valid` is 1 for real slots only.
  - Bubble slots still drive data, but their result is discarded.
- **Tag pipe:** ACC_LAT stages, each carrying {valid, i}.
  - At t+ADD_TAP, `o_a_b1_x/y` = `partial[i]` if valid, else 0.
  - At t+ACC_LAT, if valid, `partial[i]` ← `i_acc_x/y`.
  - The period rule guarantees the write for body i lands at least 1 cycle before its next read. No forwarding is needed.
- **Output:** for k=0..n−1 on consecutive cycles, `o_acc_valid`=1, `o_acc_idx`=k, `o_acc_x/y`=`partial[k]`. There is no backpressure.
- **Reset (any time, including mid-frame):**
  - FSM goes to IDLE.
  - Counters, tag pipe and `partial` clear.
  - All outputs go to 0.
  - No stale writeback from in-flight pairs occurs after reset.

## Timing
- `i_start` is sampled at edge E0. `o_busy`=1 from E0 until the cycle `o_done` is high, inclusive.
- Timeline for n≥2:
  - CLEAR cycle: E0+1.
  - First address: E0+2.
  - First issue: E0+4.
  - Last issue: E0+3+n·P.
  - DRAIN ends ACC_LAT cycles after the last issue.
  - First `o_acc_valid`: last issue + ACC_LAT + 1.
  - `o_done`: the cycle after the last result.
- Issue throughput is one slot per cycle. Real pairs per frame = n·(n−1). Bubbles per frame = n·P − n·(n−1).
- Outputs held at 0 when not active: `o_acc_*`, `o_pair_valid`, `o_a_b1_*`.

## Test plan
- **n=4, stub calculator** (result = prev + `b2_x`, ACC_LAT=24, ADD_TAP=22, body k has x=k+1) → `partial[i]` = 10−(i+1), so results are 9, 8, 7, 6. Exactly 12 `o_pair_valid` pulses; P=4.
- **n=2, same stub** → P=3; 6 slots, 2 real; results 2 and 1; first `o_acc_valid` at E0+3+6+25.
- **n=0** → `o_done` at E0+1, no `o_acc_valid`. **n=1** → one result, idx 0, value 0.
- **`i_start` pulsed in ISSUE and OUTPUT** → ignored; the frame result is identical to the undisturbed run.
- **`i_rst` asserted mid-ISSUE** → all outputs are 0 the same cycle; after release, a new n=4 frame gives 9, 8, 7, 6 with no contamination.
- **n=16 (N_MAX), P=16** → 240 real pairs and 16 results; `o_done` exactly once.
